lmc1992_rx: RTL and testbench



---
 rtl/lmc1992_pkg.sv | 40 ++++
 rtl/lmc1992_atten.sv | 73 +++++++
 rtl/lmc1992_rx.sv | 177 +++++++++++++++++
 tb/tb_lmc1992_rx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmc1992_pkg.sv
// Shared definitions for the LMC1992 microwire receiver and volume stage.
package lmc1992_pkg;

  // Function field codes carried in bits [8:6] of a command word.
  typedef enum logic [2:0] {
    FnMixer  = 3'b000,
    FnBass   = 3'b001,
    FnTreble = 3'b010,
    FnMaster = 3'b011,
    FnRight  = 3'b100,
    FnLeft   = 3'b101,
    FnRsv6   = 3'b110,
    FnRsv7   = 3'b111
  } fn_e;

  localparam logic [4:0] FrameBits = 5'd11;

  // Clamp limits.
  localparam logic [5:0] MasterMax = 6'd40;
  localparam logic [4:0] SideMax   = 5'd20;
  localparam logic [3:0] ToneMax   = 4'd12;

  // Reset values.
  localparam logic [5:0] MasterRst = 6'd40;
  localparam logic [4:0] SideRst   = 5'd20;
  localparam logic [3:0] ToneRst   = 4'd6;
  localparam logic [1:0] MixerRst  = 2'b01;

  // Q0.15 mantissas for 0, -2 and -4 dB; 6 dB steps come from the shift.
  function automatic logic [15:0] mantissa(input logic [1:0] r);
    logic [15:0] m;
    case (r)
      2'd0:    m = 16'd32767;
      2'd1:    m = 16'd26029;
      default: m = 16'd20675;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lmc1992_atten.sv
// Per-channel two-stage attenuator: stage 1 registers the signed sample and the
// total attenuation step count, stage 2 multiplies by the mantissa and shifts.
module lmc1992_atten
  import lmc1992_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sample_en,
  input  logic [7:0]  i_sample,
  input  logic [5:0]  i_master_vol,
  input  logic [4:0]  i_side_vol,
  output logic [15:0] o_sample,
  output logic        o_valid
);

  logic signed [7:0]  w_s;
  logic [5:0]         w_atten;
  logic signed [7:0]  r_s;
  logic [5:0]         r_atten;
  logic               r_v1;
  logic [5:0]         w_q;
  logic [1:0]         w_r;
  logic [5:0]         w_sh_amt;
  logic signed [24:0] w_prod;
  logic [15:0]        r_out;
  logic               r_valid;

  // Offset-binary to two's complement, and total 2 dB steps (0..60).
  always_comb begin
    w_s     = signed'(i_sample ^ 8'h80);
    w_atten = (MasterMax - i_master_vol) + (6'(SideMax) - {1'b0, i_side_vol});
  end

  // Stage 1: capture sample and attenuation using the controls of this cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s     <= '0;
      r_atten <= '0;
      r_v1    <= 1'b0;
    end else begin
      r_v1 <= i_sample_en;
      if (i_sample_en) begin
        r_s     <= w_s;
        r_atten <= w_atten;
      end
    end
  end

  // Every 3 steps is 6 dB (one extra shift); the remainder picks the mantissa.
  always_comb begin
    w_q      = r_atten / 6'd3;
    w_r      = 2'(r_atten % 6'd3);
    w_sh_amt = w_q + 6'd7;
    w_prod   = r_s * $signed({1'b0, mantissa(w_r)});
  end

  // Stage 2: register the shifted product and pulse valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_v1;
      if (r_v1) begin
        r_out <= 16'(w_prod >>> w_sh_amt);
      end
    end
  end

  assign o_sample = r_out;
  assign o_valid  = r_valid;

endmodule

// File: rtl/lmc1992_rx.sv
// Microwire receiver: synchronises the link, deserialises 11-bit commands,
// decodes them into clamped control registers and drives two attenuators.
module lmc1992_rx
  import lmc1992_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [1:0]  DEV_ADDR    = 2'b10
) (
  input  logic        i_clk32,
  input  logic        i_reset,
  input  logic        i_mw_clk,
  input  logic        i_mw_data,
  input  logic        i_mw_en_n,
  input  logic        i_sample_en,
  input  logic [7:0]  i_audio_l_in,
  input  logic [7:0]  i_audio_r_in,
  output logic [15:0] o_audio_l_out,
  output logic [15:0] o_audio_r_out,
  output logic        o_audio_valid,
  output logic [5:0]  o_master_vol,
  output logic [4:0]  o_left_vol,
  output logic [4:0]  o_right_vol,
  output logic [3:0]  o_bass,
  output logic [3:0]  o_treble,
  output logic [1:0]  o_mixer,
  output logic        o_cmd_stb,
  output logic        o_cmd_err
);

  logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync, r_en_sync;
  logic r_clk_prev, r_en_prev;
  logic w_clk_s, w_data_s, w_en_s;
  logic w_clk_rise, w_en_rise, w_en_fall;
  logic [10:0] r_sr;
  logic [4:0]  r_cnt;

  logic [5:0] r_master, w_master_nxt;
  logic [4:0] r_left, w_left_nxt, r_right, w_right_nxt;
  logic [3:0] r_bass, w_bass_nxt, r_treble, w_treble_nxt;
  logic [1:0] r_mixer, w_mixer_nxt;
  logic       r_stb, w_stb_nxt, r_err, w_err_nxt;

  logic [1:0] w_addr;
  fn_e        w_fn;
  logic [5:0] w_data;
  logic       w_valid_l, w_valid_r;

  // Synchronisers, reset to the idle link levels.
  always_ff @(posedge i_clk32 or posedge i_reset) begin
    if (i_reset) begin
      r_clk_sync  <= '0;
      r_data_sync <= '0;
      r_en_sync   <= '1;
      r_clk_prev  <= 1'b0;
      r_en_prev   <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_mw_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_mw_data};
      r_en_sync   <= {r_en_sync[SYNC_STAGES-2:0], i_mw_en_n};
      r_clk_prev  <= w_clk_s;
      r_en_prev   <= w_en_s;
    end
  end

  // Edge detection on the synchronised copies.
  always_comb begin
    w_clk_s    = r_clk_sync[SYNC_STAGES-1];
    w_data_s   = r_data_sync[SYNC_STAGES-1];
    w_en_s     = r_en_sync[SYNC_STAGES-1];
    w_clk_rise = w_clk_s & ~r_clk_prev;
    w_en_rise  = w_en_s & ~r_en_prev;
    w_en_fall  = ~w_en_s & r_en_prev;
  end

  // Shift register and saturating bit counter; both enable edges clear the count.
  always_ff @(posedge i_clk32 or posedge i_reset) begin
    if (i_reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      if (!w_en_s && w_clk_rise) begin
        r_sr <= {r_sr[9:0], w_data_s};
      end
      if (w_en_rise || w_en_fall) begin
        r_cnt <= '0;
      end else if (!w_en_s && w_clk_rise && r_cnt != 5'd31) begin
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  // Decode the last 11 bits at frame end into clamped register updates.
  always_comb begin
    w_addr       = r_sr[10:9];
    w_fn         = fn_e'(r_sr[8:6]);
    w_data       = r_sr[5:0];
    w_master_nxt = r_master;
    w_left_nxt   = r_left;
    w_right_nxt  = r_right;
    w_bass_nxt   = r_bass;
    w_treble_nxt = r_treble;
    w_mixer_nxt  = r_mixer;
    w_stb_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    if (w_en_rise && r_cnt >= FrameBits && w_addr == DEV_ADDR) begin
      w_stb_nxt = 1'b1;
      case (w_fn)
        FnMixer:  w_mixer_nxt  = w_data[1:0];
        FnBass:   w_bass_nxt   = (w_data[3:0] > ToneMax) ? ToneMax : w_data[3:0];
        FnTreble: w_treble_nxt = (w_data[3:0] > ToneMax) ? ToneMax : w_data[3:0];
        FnMaster: w_master_nxt = (w_data > MasterMax) ? MasterMax : w_data;
        FnRight:  w_right_nxt  = (w_data[4:0] > SideMax) ? SideMax : w_data[4:0];
        FnLeft:   w_left_nxt   = (w_data[4:0] > SideMax) ? SideMax : w_data[4:0];
        default: begin
          w_stb_nxt = 1'b0;
          w_err_nxt = 1'b1;
        end
      endcase
    end
  end

  // Control registers and command pulses.
  always_ff @(posedge i_clk32 or posedge i_reset) begin
    if (i_reset) begin
      r_master <= MasterRst;
      r_left   <= SideRst;
      r_right  <= SideRst;
      r_bass   <= ToneRst;
      r_treble <= ToneRst;
      r_mixer  <= MixerRst;
      r_stb    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_master <= w_master_nxt;
      r_left   <= w_left_nxt;
      r_right  <= w_right_nxt;
      r_bass   <= w_bass_nxt;
      r_treble <= w_treble_nxt;
      r_mixer  <= w_mixer_nxt;
      r_stb    <= w_stb_nxt;
      r_err    <= w_err_nxt;
    end
  end

  lmc1992_atten u_atten_l (
    .i_clk        (i_clk32),
    .i_rst        (i_reset),
    .i_sample_en  (i_sample_en),
    .i_sample     (i_audio_l_in),
    .i_master_vol (r_master),
    .i_side_vol   (r_left),
    .o_sample     (o_audio_l_out),
    .o_valid      (w_valid_l)
  );

  lmc1992_atten u_atten_r (
    .i_clk        (i_clk32),
    .i_rst        (i_reset),
    .i_sample_en  (i_sample_en),
    .i_sample     (i_audio_r_in),
    .i_master_vol (r_master),
    .i_side_vol   (r_right),
    .o_sample     (o_audio_r_out),
    .o_valid      (w_valid_r)
  );

  assign o_audio_valid = w_valid_l & w_valid_r;
  assign o_master_vol  = r_master;
  assign o_left_vol    = r_left;
  assign o_right_vol   = r_right;
  assign o_bass        = r_bass;
  assign o_treble      = r_treble;
  assign o_mixer       = r_mixer;
  assign o_cmd_stb     = r_stb;
  assign o_cmd_err     = r_err;

endmodule

// File: tb/tb_lmc1992_rx.sv
// Scoreboard bench for lmc1992_rx: a behavioural model predicts command and
// audio responses into queues; a monitor pops and compares on each DUT strobe.
module tb_lmc1992_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        mw_clk, mw_data, mw_en_n, sample_en;
  logic [7:0]  l_in, r_in;
  logic [15:0] l_out, r_out;
  logic        a_valid;
  logic [5:0]  master_vol;
  logic [4:0]  left_vol, right_vol;
  logic [3:0]  bass, treble;
  logic [1:0]  mixer;
  logic        cmd_stb, cmd_err;

  lmc1992_rx #(.SYNC_STAGES(2), .DEV_ADDR(2'b10)) dut (
    .i_clk32       (clk),
    .i_reset       (rst),
    .i_mw_clk      (mw_clk),
    .i_mw_data     (mw_data),
    .i_mw_en_n     (mw_en_n),
    .i_sample_en   (sample_en),
    .i_audio_l_in  (l_in),
    .i_audio_r_in  (r_in),
    .o_audio_l_out (l_out),
    .o_audio_r_out (r_out),
    .o_audio_valid (a_valid),
    .o_master_vol  (master_vol),
    .o_left_vol    (left_vol),
    .o_right_vol   (right_vol),
    .o_bass        (bass),
    .o_treble      (treble),
    .o_mixer       (mixer),
    .o_cmd_stb     (cmd_stb),
    .o_cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Model of the control registers.
  int m_master = 40, m_left = 20, m_right = 20, m_bass = 6, m_treble = 6, m_mixer = 1;

  typedef struct {
    bit is_err;
    int master, left, right, bass, treble, mixer;
  } cmd_t;
  typedef struct {
    logic [15:0] l, r;
    int unsigned due;
  } aud_t;

  cmd_t cmd_q[$];
  aud_t aud_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Attenuation from the dB rules: 2 dB per step, each 3 steps halve the level.
  function automatic logic [15:0] ref_atten(input logic [7:0] x, input int mv, input int sv);
    int s, a, q, r;
    longint m, p;
    s = int'(x) - 128;
    a = (40 - mv) + (20 - sv);
    q = a / 3;
    r = a % 3;
    m = (r == 0) ? 32767 : (r == 1) ? 26029 : 20675;
    p = longint'(s) * m;
    p = p >>> (7 + q);
    return p[15:0];
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_master = 40; m_left = 20; m_right = 20;
    m_bass = 6; m_treble = 6; m_mixer = 1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".master"}, master_vol, m_master);
    chk({tag, ".left"},   left_vol,   m_left);
    chk({tag, ".right"},  right_vol,  m_right);
    chk({tag, ".bass"},   bass,       m_bass);
    chk({tag, ".treble"}, treble,     m_treble);
    chk({tag, ".mixer"},  mixer,      m_mixer);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Predict the response to a frame of n bits (value right-aligned in bits).
  task automatic predict(input logic [31:0] bits, input int n);
    int addr, fn, d;
    cmd_t e;
    if (n < 11) return;
    addr = (bits >> 9) & 3;
    fn   = (bits >> 6) & 7;
    d    = bits & 63;
    if (addr != 2) return;
    e.is_err = 1'b0;
    case (fn)
      0: m_mixer  = d & 3;
      1: m_bass   = min_i(d & 15, 12);
      2: m_treble = min_i(d & 15, 12);
      3: m_master = min_i(d, 40);
      4: m_right  = min_i(d & 31, 20);
      5: m_left   = min_i(d & 31, 20);
      default: e.is_err = 1'b1;
    endcase
    e.master = m_master; e.left = m_left; e.right = m_right;
    e.bass = m_bass; e.treble = m_treble; e.mixer = m_mixer;
    cmd_q.push_back(e);
  endtask

  task automatic mw_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mw_data = bits[i];
      wait_cyc(3);
      mw_clk = 1'b1;
      wait_cyc(6);
      mw_clk = 1'b0;
      wait_cyc(5);
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, input string tag);
    predict(bits, n);
    mw_en_n = 1'b0;
    wait_cyc(4);
    mw_bits(bits, n);
    mw_en_n = 1'b1;
    wait_cyc(8);
    chk_regs(tag);
  endtask

  // Drive one sample this cycle and queue the expected output two cycles on.
  task automatic issue(input logic [7:0] l, input logic [7:0] r);
    aud_t e;
    sample_en = 1'b1;
    l_in = l;
    r_in = r;
    e.l = ref_atten(l, m_master, m_left);
    e.r = ref_atten(r, m_master, m_right);
    e.due = cyc + 2;
    aud_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_sample();
    sample_en = 1'b0;
    l_in = 8'h00;
    r_in = 8'h00;
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) issue(8'($urandom), 8'($urandom));
    idle_sample();
    wait_cyc(3);
  endtask

  // Monitor: compare every command pulse and audio strobe against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_stb || cmd_err) begin
        chk("cmd_expected", cmd_q.size() != 0, 1);
        if (cmd_q.size() != 0) begin
          cmd_t e;
          e = cmd_q.pop_front();
          chk("cmd_stb", cmd_stb, !e.is_err);
          chk("cmd_err", cmd_err, e.is_err);
          chk("cmd.master", master_vol, e.master);
          chk("cmd.left", left_vol, e.left);
          chk("cmd.right", right_vol, e.right);
          chk("cmd.bass", bass, e.bass);
          chk("cmd.treble", treble, e.treble);
          chk("cmd.mixer", mixer, e.mixer);
        end
      end
      if (a_valid) begin
        chk("aud_expected", aud_q.size() != 0, 1);
        if (aud_q.size() != 0) begin
          aud_t e;
          e = aud_q.pop_front();
          chk("aud_latency", cyc, e.due);
          chk("aud_l", $signed(l_out), $signed(e.l));
          chk("aud_r", $signed(r_out), $signed(e.r));
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    int n;
    rst = 1'b1;
    mw_clk = 1'b0; mw_data = 1'b0; mw_en_n = 1'b1;
    idle_sample();
    wait_cyc(3);
    chk_regs("reset");
    chk("reset.l_out", l_out, 0);
    chk("reset.r_out", r_out, 0);
    chk("reset.valid", a_valid, 0);
    chk("reset.stb", cmd_stb, 0);
    chk("reset.err", cmd_err, 0);
    rst = 1'b0;
    wait_cyc(4);

    // Unity gain extremes.
    issue(8'hFF, 8'h00);
    issue(8'h80, 8'h7F);
    idle_sample();
    wait_cyc(3);

    // Master volume.
    send_frame(32'b10_011_101000, 11, "master40");
    send_frame(32'b10_011_011110, 11, "master30");
    issue(8'hFF, 8'hFF);
    idle_sample();
    wait_cyc(3);

    // Clamping.
    send_frame(32'b10_100_111111, 11, "right_clamp");
    send_frame(32'b10_001_001111, 11, "bass_clamp");
    send_frame(32'b10_010_001101, 11, "treble_clamp");
    send_frame(32'b10_000_000011, 11, "mixer");

    // Frame length.
    send_frame(32'b10_011_0000, 9, "short9");
    send_frame({18'd0, 3'b101, 11'b10_101_001010}, 14, "long14");

    // Address / function.
    send_frame(32'b01_011_000000, 11, "bad_addr");
    send_frame(32'b10_111_000101, 11, "fn111");
    send_frame(32'b10_110_000000, 11, "fn110");

    // Maximum attenuation, back-to-back samples.
    send_frame(32'b10_011_000000, 11, "master0");
    send_frame(32'b10_100_000000, 11, "right0");
    send_frame(32'b10_101_000000, 11, "left0");
    issue(8'h00, 8'hFF);
    issue(8'hFF, 8'h00);
    issue(8'h01, 8'h80);
    idle_sample();
    wait_cyc(3);

    // Reset mid-frame: 6 bits then reset, then a fresh full frame.
    mw_en_n = 1'b0;
    wait_cyc(4);
    mw_bits(32'b10_0110, 6);
    rst = 1'b1;
    mw_en_n = 1'b1; mw_clk = 1'b0; mw_data = 1'b0;
    model_reset();
    wait_cyc(3);
    chk_regs("in_reset");
    rst = 1'b0;
    wait_cyc(4);
    chk_regs("after_reset");
    send_frame(32'b10_101_001100, 11, "post_reset");
    burst(5);

    // Randomised frames and sample bursts.
    for (int k = 0; k < 30; k++) begin
      v = $urandom;
      n = $urandom_range(8, 14);
      if ($urandom_range(0, 9) < 8) begin
        v[10:9] = 2'b10;
      end
      v = v & ((32'd1 << n) - 1);
      send_frame(v, n, "rand_frame");
      burst($urandom_range(1, 6));
    end

    wait_cyc(10);
    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("aud_q_drained", aud_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
